// File: rtl/piso_shift_param_if.sv
// Load handshake and serial line bundle for piso_shift_param.
// master = word producer / line driver side, slave = the shifter.
interface piso_shift_param_if #(
    parameter int WIDTH = 8
) ();
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_en;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;

    modport master (
        output load_valid, load_data, ser_en,
        input  load_ready, ser_out, ser_valid, ser_last
    );

    modport slave (
        input  load_valid, load_data, ser_en,
        output load_ready, ser_out, ser_valid, ser_last
    );
endinterface

// File: rtl/piso_shift_param.sv
// Parameterised parallel-in serial-out shifter with valid/ready load, shift-enable
// stall, last-bit flag and gap-free reload on the final bit of a word.
module piso_shift_param #(
    parameter int   WIDTH      = 8,
    parameter bit   LSB_FIRST  = 1'b0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    piso_shift_param_if.slave bus
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt, sreg_shift;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             last;
    logic             head_bit;

    // The bit on the line is always the end of sreg nearest ser_out; shifting
    // pulls the next bit toward that end and zero-fills the far end.
    generate
        if (LSB_FIRST) begin : g_lsb
            assign sreg_shift = {1'b0, sreg[WIDTH-1:1]};
            assign head_bit   = sreg[0];
        end else begin : g_msb
            assign sreg_shift = {sreg[WIDTH-2:0], 1'b0};
            assign head_bit   = sreg[WIDTH-1];
        end
    endgenerate

    assign last = (state == SHIFT) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // load_ready depends on ser_en only, never on load_valid.
    always_comb begin
        state_nxt      = state;
        sreg_nxt       = sreg;
        cnt_nxt        = cnt;
        bus.load_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.load_ready = 1'b1;
                if (bus.load_valid) begin
                    sreg_nxt  = bus.load_data;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.ser_en) begin
                    if (last) begin
                        bus.load_ready = 1'b1;
                        if (bus.load_valid) begin
                            sreg_nxt = bus.load_data;
                            cnt_nxt  = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        sreg_nxt = sreg_shift;
                        cnt_nxt  = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ser_valid = (state == SHIFT);
    assign bus.ser_last  = last;
    assign bus.ser_out   = (state == SHIFT) ? head_bit : IDLE_LEVEL;

    a_capture_only_at_last: assert property (@(posedge clk) disable iff (rst)
        (state == SHIFT && bus.load_valid && bus.load_ready) |-> (last && bus.ser_en));

    a_last_once_per_word: assert property (@(posedge clk) disable iff (rst)
        (last && bus.ser_en) |=> !bus.ser_last);

endmodule

// File: tb/tb_piso_shift_param.sv
// Directed bench for piso_shift_param: per-cycle vector table on an 8-bit MSB-first
// instance, plus hand sequences on LSB-first and 2-bit/idle-high instances.
module tb_piso_shift_param;
    logic clk = 1'b0;
    logic rst_a, rst_bc;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    piso_shift_param_if #(.WIDTH(8)) bus_a ();
    piso_shift_param_if #(.WIDTH(8)) bus_b ();
    piso_shift_param_if #(.WIDTH(2)) bus_c ();

    piso_shift_param #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a.slave));
    piso_shift_param #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .rst(rst_bc), .bus(bus_b.slave));
    piso_shift_param #(.WIDTH(2), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_c (
        .clk(clk), .rst(rst_bc), .bus(bus_c.slave));

    typedef struct {
        logic       rst;
        logic       lv;
        logic [7:0] data;
        logic       en;
        logic       out;
        logic       vld;
        logic       last;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic push(input logic r, input logic lv, input logic [7:0] d, input logic en,
                        input logic o, input logic v, input logic l, input logic rd);
        vec_t x;
        x.rst = r; x.lv = lv; x.data = d; x.en = en;
        x.out = o; x.vld = v; x.last = l; x.rdy = rd;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] w_b2, w_f0, w_0f, exp_b;
        int         nbits;
        w_b2 = 8'hB2; w_f0 = 8'hF0; w_0f = 8'h0F;

        // Test 1: single word, MSB first
        push(0, 1, w_b2, 1, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) push(0, 0, 8'h00, 1, w_b2[7-i], 1, i == 7, i == 7);
        push(0, 0, 8'h00, 1, 0, 0, 0, 1);
        // Test 3: back-to-back, load_valid held with the second word
        push(0, 1, w_f0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) push(0, 1, w_0f, 1, w_f0[7-i], 1, i == 7, i == 7);
        for (int i = 0; i < 8; i++) push(0, 0, 8'h00, 1, w_0f[7-i], 1, i == 7, i == 7);
        push(0, 0, 8'h00, 1, 0, 0, 0, 1);
        // Test 4: stall after the 2nd bit, junk presented while not ready
        push(0, 1, w_b2, 1, 0, 0, 0, 1);
        push(0, 0, 8'h00, 1, 1, 1, 0, 0);
        push(0, 0, 8'h00, 1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) push(0, 1, 8'hFF, 0, 1, 1, 0, 0);
        for (int i = 2; i < 8; i++) push(0, 0, 8'h00, 1, w_b2[7-i], 1, i == 7, i == 7);
        push(0, 0, 8'h00, 1, 0, 0, 0, 1);
        // Test 5: reset after 3 bits with a competing load
        push(0, 1, w_b2, 1, 0, 0, 0, 1);
        push(0, 0, 8'h00, 1, 1, 1, 0, 0);
        push(0, 0, 8'h00, 1, 0, 1, 0, 0);
        push(1, 1, 8'h55, 1, 1, 1, 0, 0);
        push(0, 0, 8'h00, 1, 0, 0, 0, 1);
        push(0, 0, 8'h55, 0, 0, 0, 0, 1);

        rst_a = 1; rst_bc = 1;
        bus_a.load_valid = 0; bus_a.load_data = '0; bus_a.ser_en = 0;
        bus_b.load_valid = 0; bus_b.load_data = '0; bus_b.ser_en = 0;
        bus_c.load_valid = 0; bus_c.load_data = '0; bus_c.ser_en = 0;
        repeat (2) @(negedge clk);
        rst_a = 0; rst_bc = 0;
        #1;
        check("rst_a_valid", bus_a.ser_valid, 1'b0);
        check("rst_a_last",  bus_a.ser_last,  1'b0);
        check("rst_a_out",   bus_a.ser_out,   1'b0);
        check("rst_a_ready", bus_a.load_ready, 1'b1);
        check("rst_c_out",   bus_c.ser_out,   1'b1);
        check("rst_c_ready", bus_c.load_ready, 1'b1);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_a = vecs[i].rst;
            bus_a.load_valid = vecs[i].lv;
            bus_a.load_data  = vecs[i].data;
            bus_a.ser_en     = vecs[i].en;
            #1;
            check($sformatf("v%0d_out", i),   bus_a.ser_out,    vecs[i].out);
            check($sformatf("v%0d_valid", i), bus_a.ser_valid,  vecs[i].vld);
            check($sformatf("v%0d_last", i),  bus_a.ser_last,   vecs[i].last);
            check($sformatf("v%0d_ready", i), bus_a.load_ready, vecs[i].rdy);
        end
        @(negedge clk);
        rst_a = 0; bus_a.load_valid = 0; bus_a.ser_en = 0;

        // Test 2: LSB first, count valid cycles within a bounded window
        exp_b = 8'hB2;
        bus_b.load_valid = 1; bus_b.load_data = 8'hB2; bus_b.ser_en = 1;
        nbits = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bus_b.load_valid = 0;
            #1;
            if (bus_b.ser_valid) begin
                if (nbits < 8) begin
                    check($sformatf("lsb_bit%0d", nbits), bus_b.ser_out, exp_b[nbits]);
                    check($sformatf("lsb_last%0d", nbits), bus_b.ser_last, nbits == 7);
                end
                nbits++;
            end
        end
        n_run++;
        if (nbits != 8) begin
            n_fail++;
            $display("FAIL lsb_valid_cycles: got %0d, expected 8", nbits);
        end

        // Test 6: WIDTH=2, idle level 1
        @(negedge clk);
        bus_c.load_valid = 1; bus_c.load_data = 2'b01; bus_c.ser_en = 1;
        #1;
        check("w2_idle_out",   bus_c.ser_out,    1'b1);
        check("w2_idle_ready", bus_c.load_ready, 1'b1);
        @(negedge clk);
        bus_c.load_valid = 0;
        #1;
        check("w2_bit0",   bus_c.ser_out,   1'b0);
        check("w2_valid0", bus_c.ser_valid, 1'b1);
        check("w2_last0",  bus_c.ser_last,  1'b0);
        check("w2_ready0", bus_c.load_ready, 1'b0);
        @(negedge clk);
        #1;
        check("w2_bit1",   bus_c.ser_out,   1'b1);
        check("w2_last1",  bus_c.ser_last,  1'b1);
        check("w2_ready1", bus_c.load_ready, 1'b1);
        @(negedge clk);
        #1;
        check("w2_after_out",   bus_c.ser_out,    1'b1);
        check("w2_after_valid", bus_c.ser_valid,  1'b0);
        check("w2_after_ready", bus_c.load_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
